secuenciador_operandos: RTL and testbench

// Front-end stage for the parametrised ripple-carry adder (sumador).
// - Captures operand A, then operand B, from a shared input bus on successive rising edges of a load strobe.
// - Drives num1/num2 into the adder and registers the adder's Resul/Cout one cycle later.
// - Holds the sum with a valid flag.
// - Supports chained accumulation: the previous sum becomes the next operand A.
// - Sits between board inputs (switches/buttons) and the display logic.

---
 rtl/paquete_sumador.sv | 13 +
 rtl/detector_flanco.sv | 30 +++
 rtl/secuenciador_operandos.sv | 119 +++++++++++
 tb/tb_secuenciador_operandos.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/paquete_sumador.sv
// Shared types for the operand sequencer that feeds the ripple-carry adder.
package paquete_sumador;

    typedef enum logic [1:0] {
        ESPERA_A = 2'd0,
        ESPERA_B = 2'd1,
        CALCULA  = 2'd2,
        MUESTRA  = 2'd3
    } estado_t;

    localparam int BITS_DEF = 4;

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector producing a one-cycle pulse. A level that is already
// high when reset is released is not reported until it has been seen low.
module detector_flanco (
    input  logic clk,
    input  logic rst_n,
    input  logic senal,
    output logic flanco
);

    logic senal_q, senal_d;
    logic armado_q, armado_d;

    always_comb begin
        senal_d  = senal;
        armado_d = armado_q | ~senal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            senal_q  <= 1'b0;
            armado_q <= 1'b0;
        end else begin
            senal_q  <= senal_d;
            armado_q <= armado_d;
        end
    end

    assign flanco = senal & ~senal_q & armado_q;

endmodule

// File: rtl/secuenciador_operandos.sv
// Operand sequencer: loads A then B from a shared bus, registers the adder
// result, and supports chaining the previous sum back in as operand A.
module secuenciador_operandos
    import paquete_sumador::*;
#(
    parameter int BITS = BITS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] dato_in,
    input  logic            cargar,
    input  logic            acumular,
    input  logic            limpiar,
    output logic [BITS-1:0] num1,
    output logic [BITS-1:0] num2,
    input  logic [BITS-1:0] resul_in,
    input  logic            cout_in,
    output logic [BITS-1:0] resultado,
    output logic            carry,
    output logic            valido,
    output logic [1:0]      estado
);

    logic flanco;

    estado_t         estado_q, estado_d;
    logic [BITS-1:0] num1_q, num1_d;
    logic [BITS-1:0] num2_q, num2_d;
    logic [BITS-1:0] resultado_q, resultado_d;
    logic            carry_q, carry_d;
    logic            valido_q, valido_d;

    detector_flanco u_detector (
        .clk    (clk),
        .rst_n  (rst_n),
        .senal  (cargar),
        .flanco (flanco)
    );

    always_comb begin
        estado_d    = estado_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        resultado_d = resultado_q;
        carry_d     = carry_q;
        valido_d    = valido_q;

        if (limpiar) begin
            estado_d    = ESPERA_A;
            num1_d      = '0;
            num2_d      = '0;
            resultado_d = '0;
            carry_d     = 1'b0;
            valido_d    = 1'b0;
        end else begin
            case (estado_q)
                ESPERA_A: begin
                    if (flanco) begin
                        num1_d   = dato_in;
                        estado_d = ESPERA_B;
                    end
                end
                ESPERA_B: begin
                    if (flanco) begin
                        num2_d   = dato_in;
                        estado_d = CALCULA;
                    end
                end
                // Adder inputs have been stable for a full cycle here.
                CALCULA: begin
                    resultado_d = resul_in;
                    carry_d     = cout_in;
                    valido_d    = 1'b1;
                    estado_d    = MUESTRA;
                end
                MUESTRA: begin
                    if (flanco) begin
                        valido_d = 1'b0;
                        if (acumular) begin
                            num1_d   = resultado_q;
                            num2_d   = dato_in;
                            estado_d = CALCULA;
                        end else begin
                            num1_d   = dato_in;
                            estado_d = ESPERA_B;
                        end
                    end
                end
                default: estado_d = ESPERA_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= ESPERA_A;
            num1_q      <= '0;
            num2_q      <= '0;
            resultado_q <= '0;
            carry_q     <= 1'b0;
            valido_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            resultado_q <= resultado_d;
            carry_q     <= carry_d;
            valido_q    <= valido_d;
        end
    end

    assign num1      = num1_q;
    assign num2      = num2_q;
    assign resultado = resultado_q;
    assign carry     = carry_q;
    assign valido    = valido_q;
    assign estado    = estado_q;

endmodule

// File: tb/tb_secuenciador_operandos.sv
// Bench for secuenciador_operandos with a behavioural adder and a cycle-level
// reference model of the load/accumulate sequence.
module tb_secuenciador_operandos;

    localparam int BITS = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [BITS-1:0] dato_in;
    logic            cargar;
    logic            acumular;
    logic            limpiar;
    logic [BITS-1:0] num1;
    logic [BITS-1:0] num2;
    logic [BITS-1:0] resul_in;
    logic            cout_in;
    logic [BITS-1:0] resultado;
    logic            carry;
    logic            valido;
    logic [1:0]      estado;

    always #5 clk = ~clk;

    // Stand-in for the sumador instance the parent would connect.
    assign {cout_in, resul_in} = {1'b0, num1} + {1'b0, num2};

    secuenciador_operandos #(.BITS(BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dato_in   (dato_in),
        .cargar    (cargar),
        .acumular  (acumular),
        .limpiar   (limpiar),
        .num1      (num1),
        .num2      (num2),
        .resul_in  (resul_in),
        .cout_in   (cout_in),
        .resultado (resultado),
        .carry     (carry),
        .valido    (valido),
        .estado    (estado)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0..3, operands, held sum, and strobe history.
    int m_phase, m_a, m_b, m_s, m_c, m_v;
    int m_prev, m_armed;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_phase = 0; m_a = 0; m_b = 0; m_s = 0; m_c = 0; m_v = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_prev  = 0;
        m_armed = 0;
    endtask

    task automatic model_step();
        int edge_seen;
        int din;
        din       = int'(dato_in);
        edge_seen = (cargar && m_prev == 0 && m_armed != 0) ? 1 : 0;
        if (!cargar) m_armed = 1;
        m_prev = cargar ? 1 : 0;
        if (limpiar) begin
            model_clear();
        end else if (m_phase == 0) begin
            if (edge_seen != 0) begin m_a = din; m_phase = 1; end
        end else if (m_phase == 1) begin
            if (edge_seen != 0) begin m_b = din; m_phase = 2; end
        end else if (m_phase == 2) begin
            m_s = (m_a + m_b) % 16;
            m_c = (m_a + m_b) >= 16 ? 1 : 0;
            m_v = 1;
            m_phase = 3;
        end else begin
            if (edge_seen != 0) begin
                m_v = 0;
                if (acumular) begin
                    m_a = m_s; m_b = din; m_phase = 2;
                end else begin
                    m_a = din; m_phase = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        comprobar("estado",    32'(estado),    32'(m_phase));
        comprobar("num1",      32'(num1),      32'(m_a));
        comprobar("num2",      32'(num2),      32'(m_b));
        comprobar("resultado", 32'(resultado), 32'(m_s));
        comprobar("carry",     32'(carry),     32'(m_c));
        comprobar("valido",    32'(valido),    32'(m_v));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        compare_all();
    endtask

    task automatic load(input int v);
        dato_in = BITS'(v);
        cargar  = 1'b1;
        tick();
        cargar  = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; dato_in = '0; cargar = 1'b0; acumular = 1'b0; limpiar = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        tick();

        // Basic add with latency check on the B edge.
        load(3);
        dato_in = 4'd5; cargar = 1'b1;
        tick();
        comprobar("b_edge_calcula", 32'(estado), 32'd2);
        comprobar("b_edge_not_valid", 32'(valido), 32'd0);
        cargar = 1'b0;
        tick();
        comprobar("basic_res", 32'(resultado), 32'd8);
        comprobar("basic_carry", 32'(carry), 32'd0);
        comprobar("basic_valid", 32'(valido), 32'd1);

        // Carry out cases.
        load(9); load(9);
        comprobar("c99_res", 32'(resultado), 32'd2);
        comprobar("c99_carry", 32'(carry), 32'd1);
        load(15); load(1);
        comprobar("c151_res", 32'(resultado), 32'd0);
        comprobar("c151_carry", 32'(carry), 32'd1);

        // Accumulate chain starting from 8.
        load(3); load(5);
        acumular = 1'b1;
        load(9);
        comprobar("acc1_num1", 32'(num1), 32'd8);
        comprobar("acc1_res", 32'(resultado), 32'd1);
        comprobar("acc1_carry", 32'(carry), 32'd1);
        load(2);
        acumular = 1'b0;
        comprobar("acc2_res", 32'(resultado), 32'd3);
        comprobar("acc2_carry", 32'(carry), 32'd0);

        // Held strobe gives a single load.
        limpiar = 1'b1;
        tick();
        limpiar = 1'b0;
        comprobar("clr_state", 32'(estado), 32'd0);
        dato_in = 4'd6; cargar = 1'b1;
        repeat (10) tick();
        comprobar("held_state", 32'(estado), 32'd1);
        comprobar("held_num1", 32'(num1), 32'd6);
        cargar = 1'b0;
        tick();

        // Clear beats a simultaneous load edge.
        dato_in = 4'd7; cargar = 1'b1; limpiar = 1'b1;
        tick();
        comprobar("clr_mid_state", 32'(estado), 32'd0);
        comprobar("clr_mid_num1", 32'(num1), 32'd0);
        comprobar("clr_mid_num2", 32'(num2), 32'd0);
        limpiar = 1'b0; cargar = 1'b0;
        tick();

        // Asynchronous reset during CALCULA with the strobe left high.
        load(4);
        dato_in = 4'd11; cargar = 1'b1;
        tick();
        comprobar("pre_rst_calcula", 32'(estado), 32'd2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        comprobar("rst_valid", 32'(valido), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        comprobar("rst_held_no_load", 32'(estado), 32'd0);
        comprobar("rst_held_num1", 32'(num1), 32'd0);
        cargar = 1'b0;
        tick();
        cargar = 1'b1;
        tick();
        comprobar("rst_toggle_load", 32'(estado), 32'd1);
        comprobar("rst_toggle_num1", 32'(num1), 32'd11);
        cargar = 1'b0;
        tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) != 0) cargar = ~cargar;
            acumular = 1'($urandom_range(0, 1));
            limpiar  = ($urandom_range(0, 39) == 0);
            dato_in  = BITS'($urandom_range(0, 15));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
